// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one fixed-latency unified memory port between the CPU
//             instruction-fetch requester (read-only) and the data requester
//             (read/write). One access at a time, round-robin on ties, and a
//             one-cycle ack per completed access.
//  Ports    : clk, rst_n           - clock, synchronous active-low reset
//             i_req/i_addr         - fetch request and address
//             i_ack/i_rdata        - fetch completion pulse and read data
//             d_req/d_wr/d_addr/d_wdata - data request, direction, addr, data
//             d_ack/d_rdata        - data completion pulse and read data
//             mem_en/mem_wr/mem_addr/mem_wdata - memory command side
//             mem_rdata            - memory read data (valid in last mem_en cycle)
//             busy                 - high while an access is in BUSY or DONE
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int c_cnt_w = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(LATENCY - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_busy = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  // Grant owner encoding, shared by r_owner and r_last_grant
  localparam logic c_fetch = 1'b0;
  localparam logic c_data  = 1'b1;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_owner;
  logic               r_last_grant;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_mem_wr;
  logic [DATA_W-1:0]  r_rdata;
  logic               w_any_req;
  logic               w_grant_data;

  assign w_any_req = i_req | d_req;

  // Data wins when it is the only requester, or on a tie when fetch was the
  // previous winner. last_grant resets to fetch so data wins the first tie.
  assign w_grant_data = d_req & (~i_req | (r_last_grant == c_fetch));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:  if (w_any_req) w_state_next = c_busy;
      c_busy:  if (r_cnt == '0) w_state_next = c_done;
      c_done:  w_state_next = c_idle;
      default: w_state_next = c_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: grant capture, latency counter, shared read-data register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_owner      <= c_fetch;
      r_last_grant <= c_fetch;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wr     <= 1'b0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_any_req) begin
            r_cnt        <= c_cnt_load;
            r_owner      <= w_grant_data ? c_data : c_fetch;
            r_last_grant <= w_grant_data ? c_data : c_fetch;
            if (w_grant_data) begin
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
              r_mem_wr    <= d_wr;
            end else begin
              r_mem_addr  <= i_addr;
              r_mem_wdata <= '0;
              r_mem_wr    <= 1'b0;
            end
          end
        end
        c_busy: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            // Writes return zero so a stale read value is never re-acked
            r_rdata <= r_mem_wr ? '0 : mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    mem_en = 1'b0;
    mem_wr = 1'b0;
    i_ack  = 1'b0;
    d_ack  = 1'b0;
    busy   = 1'b0;
    case (r_state)
      c_busy: begin
        mem_en = 1'b1;
        mem_wr = r_mem_wr;
        busy   = 1'b1;
      end
      c_done: begin
        i_ack = (r_owner == c_fetch);
        d_ack = (r_owner == c_data);
        busy  = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_rdata;
  assign d_rdata   = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none

module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ack;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample point is 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_en, mem_wr, i_ack, d_ack, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle: ctrl=%b expected 00000", {mem_en, mem_wr, i_ack, d_ack, busy});
    end
    // Start a write and reset it while BUSY
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0BEE; d_wdata = 16'hCAFE;
    tick();
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0BEE) begin
      errors++;
      $display("FAIL reset_pre_busy: mem_en=%b addr=%h expected 1 0bee", mem_en, mem_addr);
    end
    rst_n = 1'b0;
    d_req = 1'b0;
    tick();
    checks++;
    if ({mem_en, mem_wr, i_ack, d_ack, busy} !== 5'b0 || mem_addr !== 16'h0 ||
        mem_wdata !== 16'h0 || i_rdata !== 16'h0 || d_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_abort: ctrl=%b addr=%h wdata=%h rdata=%h expected all 0",
               {mem_en, mem_wr, i_ack, d_ack, busy}, mem_addr, mem_wdata, i_rdata);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (mem_en !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
        errors++;
        $display("FAIL reset_release c%0d: mem_en=%b i_ack=%b d_ack=%b expected 0 0 0",
                 c, mem_en, i_ack, d_ack);
      end
    end
  endtask

  task automatic test_fetch_read();
    mem_rdata = 16'hA5A5;
    i_req = 1'b1; i_addr = 16'h0010;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c <= 4) begin
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0010 || mem_wr !== 1'b0 ||
            i_ack !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL fetch_busy c%0d: en=%b addr=%h wr=%b ack=%b busy=%b expected 1 0010 0 0 1",
                   c, mem_en, mem_addr, mem_wr, i_ack, busy);
        end
      end else begin
        checks++;
        if (mem_en !== 1'b0 || i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== 16'hA5A5) begin
          errors++;
          $display("FAIL fetch_ack: en=%b i_ack=%b d_ack=%b rdata=%h expected 0 1 0 a5a5",
                   mem_en, i_ack, d_ack, i_rdata);
        end
      end
    end
    i_req = 1'b0;
    tick();
    checks++;
    if (i_ack !== 1'b0 || mem_en !== 1'b0 || i_rdata !== 16'hA5A5) begin
      errors++;
      $display("FAIL fetch_after: ack=%b en=%b rdata=%h expected 0 0 a5a5", i_ack, mem_en, i_rdata);
    end
  endtask

  task automatic test_data_write();
    mem_rdata = 16'hFFFF;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c <= 4) begin
        checks++;
        if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0200 ||
            mem_wdata !== 16'h1234 || d_ack !== 1'b0 || i_ack !== 1'b0) begin
          errors++;
          $display("FAIL write_busy c%0d: en=%b wr=%b addr=%h wdata=%h expected 1 1 0200 1234",
                   c, mem_en, mem_wr, mem_addr, mem_wdata);
        end
      end else begin
        checks++;
        if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_rdata !== 16'h0 || mem_en !== 1'b0 || mem_wr !== 1'b0) begin
          errors++;
          $display("FAIL write_ack: d_ack=%b i_ack=%b d_rdata=%h en=%b wr=%b expected 1 0 0000 0 0",
                   d_ack, i_ack, d_rdata, mem_en, mem_wr);
        end
      end
    end
    d_req = 1'b0; d_wr = 1'b0;
    tick();
  endtask

  task automatic test_tie_after_reset();
    do_reset();
    mem_rdata = 16'h5555;
    i_req = 1'b1; i_addr = 16'h0030;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0400;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin
        checks++;
        if (mem_addr !== 16'h0400 || mem_en !== 1'b1) begin
          errors++;
          $display("FAIL tie_first_grant: addr=%h en=%b expected 0400 1", mem_addr, mem_en);
        end
      end
      if (c == 5) begin
        checks++;
        if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_rdata !== 16'h5555) begin
          errors++;
          $display("FAIL tie_d_ack: d_ack=%b i_ack=%b d_rdata=%h expected 1 0 5555", d_ack, i_ack, d_rdata);
        end
        d_req = 1'b0;
        mem_rdata = 16'h7777;
      end
      if (c == 6) begin
        checks++;
        if (mem_en !== 1'b0 || busy !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
          errors++;
          $display("FAIL tie_idle6: en=%b busy=%b acks=%b%b expected 0 0 00", mem_en, busy, i_ack, d_ack);
        end
      end
      if (c == 7) begin
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0030) begin
          errors++;
          $display("FAIL tie_second_grant: en=%b addr=%h expected 1 0030", mem_en, mem_addr);
        end
      end
      if (c == 11) begin
        checks++;
        if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== 16'h7777) begin
          errors++;
          $display("FAIL tie_i_ack: i_ack=%b d_ack=%b i_rdata=%h expected 1 0 7777", i_ack, d_ack, i_rdata);
        end
        i_req = 1'b0;
      end
      if (c == 12) begin
        checks++;
        if (i_ack !== 1'b0 || mem_en !== 1'b0) begin
          errors++;
          $display("FAIL tie_after: i_ack=%b en=%b expected 0 0", i_ack, mem_en);
        end
      end
    end
  endtask

  // Previous test ended with a fetch grant, so data wins the next tie
  task automatic test_round_robin();
    logic [1:0] exp_acks;
    mem_rdata = 16'h0F0F;
    i_req = 1'b1; i_addr = 16'h0050;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0600;
    for (int c = 1; c <= 24; c++) begin
      tick();
      // {i_ack, d_ack} expected: D at 5, I at 11, D at 17, I at 23
      case (c)
        5, 17:   exp_acks = 2'b01;
        11, 23:  exp_acks = 2'b10;
        default: exp_acks = 2'b00;
      endcase
      checks++;
      if ({i_ack, d_ack} !== exp_acks) begin
        errors++;
        $display("FAIL rr_acks c%0d: {i_ack,d_ack}=%b expected %b", c, {i_ack, d_ack}, exp_acks);
      end
      if (c == 23) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    checks++;
    if (mem_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_end: en=%b busy=%b expected 0 0", mem_en, busy);
    end
  endtask

  task automatic test_withdrawn_req();
    mem_rdata = 16'h3C3C;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0700;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 2) d_req = 1'b0;
      if (c <= 4) begin
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0700) begin
          errors++;
          $display("FAIL withdraw_busy c%0d: en=%b addr=%h expected 1 0700", c, mem_en, mem_addr);
        end
      end else if (c == 5) begin
        checks++;
        if (d_ack !== 1'b1 || mem_en !== 1'b0 || d_rdata !== 16'h3C3C) begin
          errors++;
          $display("FAIL withdraw_ack: d_ack=%b en=%b d_rdata=%h expected 1 0 3c3c", d_ack, mem_en, d_rdata);
        end
      end else begin
        checks++;
        if (d_ack !== 1'b0 || mem_en !== 1'b0) begin
          errors++;
          $display("FAIL withdraw_after: d_ack=%b en=%b expected 0 0", d_ack, mem_en);
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    i_req     = 1'b0;
    i_addr    = 16'h0;
    d_req     = 1'b0;
    d_wr      = 1'b0;
    d_addr    = 16'h0;
    d_wdata   = 16'h0;
    mem_rdata = 16'h0;
    #1;
    test_reset();
    test_fetch_read();
    test_data_write();
    test_tie_after_reset();
    test_round_robin();
    test_withdrawn_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
